param_cnn_core: RTL and testbench

Parametrised streaming classifier core: N_CH convolution kernels of size K×K, ReLU, fully-connected layer to N_CLASS scores, and argmax. It replaces the fixed 28×28 / 5×5 / 1-channel / 10-class classifier. The FC layer is fused into the convolution stream, so there is no feature-map buffer. Windows arrive over a valid/ready handshake at up to one per cycle. FC weights come from an external synchronous ROM.

---
 rtl/param_cnn_core_pkg.sv | 27 ++
 rtl/param_cnn_core_window_mac.sv | 32 +++
 rtl/param_cnn_core.sv | 160 ++++++++++++++++
 tb/tb_param_cnn_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_cnn_core_pkg.sv
// Shared FSM encoding and width helpers for the parametrised streaming CNN classifier.
package param_cnn_core_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_DRAIN,
    S_ARGMAX,
    S_FIN
  } state_t;

  // Ceiling log2, floored at 1 so the result is always a usable vector width.
  function automatic int unsigned cnn_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  // Width that holds one channel's signed K*K dot product without overflow.
  function automatic int unsigned conv_sum_w(input int unsigned pix_w,
                                             input int unsigned wt_w,
                                             input int unsigned k);
    return pix_w + wt_w + cnn_clog2(k * k) + 1;
  endfunction

endpackage

// File: rtl/param_cnn_core_window_mac.sv
// One channel's K x K multiply-accumulate over an unsigned pixel window, followed by ReLU.
module param_cnn_core_window_mac
  import param_cnn_core_pkg::*;
#(
  parameter  int unsigned K     = 5,
  parameter  int unsigned PIX_W = 8,
  parameter  int unsigned WT_W  = 8,
  localparam int unsigned SUM_W = conv_sum_w(PIX_W, WT_W, K)
) (
  input  logic [K*K*PIX_W-1:0] win,
  input  logic [K*K*WT_W-1:0]  wts,
  output logic [SUM_W-1:0]     relu_c
);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] px;
  logic signed [SUM_W-1:0] wt;

  // Pixels are zero-extended, weights sign-extended; element (0,0) sits in the MSBs.
  always_comb begin
    sum = '0;
    px  = '0;
    wt  = '0;
    for (int n = 0; n < int'(K * K); n++) begin
      px  = SUM_W'(win[(K*K-1-n)*PIX_W +: PIX_W]);
      wt  = SUM_W'($signed(wts[(K*K-1-n)*WT_W +: WT_W]));
      sum = sum + px * wt;
    end
    relu_c = sum[SUM_W-1] ? '0 : sum;
  end

endmodule

// File: rtl/param_cnn_core.sv
// Streaming classifier: per-window conv + ReLU, FC fused into the stream, then sequential argmax.
module param_cnn_core
  import param_cnn_core_pkg::*;
#(
  parameter  int unsigned IMG_W   = 28,
  parameter  int unsigned K       = 5,
  parameter  int unsigned N_CH    = 1,
  parameter  int unsigned N_CLASS = 10,
  parameter  int unsigned PIX_W   = 8,
  parameter  int unsigned WT_W    = 8,
  parameter  int unsigned ACC_W   = 40,
  localparam int unsigned OUT_W   = IMG_W - K + 1,
  localparam int unsigned N_WIN   = OUT_W * OUT_W,
  localparam int unsigned IDX_W   = cnn_clog2(N_WIN),
  localparam int unsigned CLS_W   = cnn_clog2(N_CLASS)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         WIN_VALID,
  output logic                         WIN_READY,
  input  logic [K*K*PIX_W-1:0]         WIN_DATA,
  input  logic [N_CH*K*K*WT_W-1:0]     CONV_W,
  output logic [IDX_W-1:0]             FC_ADDR,
  input  logic [N_CH*N_CLASS*WT_W-1:0] FC_RDATA,
  output logic                         DONE,
  output logic [CLS_W-1:0]             OUT,
  output logic [ACC_W-1:0]             SCORE
);

  localparam int unsigned SUM_W = conv_sum_w(PIX_W, WT_W, K);

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic                    last_win;
  logic                    last_cls;
  logic                    frame_start;
  logic                    arg_step;
  logic                    fin;
  logic [IDX_W-1:0]        cnt;
  logic [CLS_W-1:0]        cls;
  logic [CLS_W-1:0]        best_idx;
  logic signed [ACC_W-1:0] best;
  logic                    s1_valid;
  logic [N_CH*SUM_W-1:0]   relu_c;
  logic [N_CH*SUM_W-1:0]   relu_q;
  logic signed [ACC_W-1:0] acc    [N_CLASS];
  logic signed [ACC_W-1:0] fc_sum [N_CLASS];

  assign accept   = WIN_VALID & WIN_READY;
  assign last_win = (cnt == IDX_W'(N_WIN - 1));
  assign last_cls = (cls == CLS_W'(N_CLASS - 1));
  assign FC_ADDR  = cnt;

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_mac
    param_cnn_core_window_mac #(
      .K    (K),
      .PIX_W(PIX_W),
      .WT_W (WT_W)
    ) u_mac (
      .win   (WIN_DATA),
      .wts   (CONV_W[(N_CH-1-c)*K*K*WT_W +: K*K*WT_W]),
      .relu_c(relu_c[c*SUM_W +: SUM_W])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (START) state_next = S_CONV;
      S_CONV:   if (accept && last_win) state_next = S_DRAIN;
      S_DRAIN:  state_next = S_ARGMAX;
      S_ARGMAX: if (last_cls) state_next = S_FIN;
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    arg_step    = 1'b0;
    fin         = 1'b0;
    case (state)
      S_IDLE:   frame_start = START;
      S_ARGMAX: arg_step    = 1'b1;
      S_FIN:    fin         = 1'b1;
      default:  ;
    endcase
  end

  // Window counter and stage-1 ReLU registers; ready tracks the upcoming CONV state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WIN_READY <= 1'b0;
      cnt       <= '0;
      s1_valid  <= 1'b0;
      relu_q    <= '0;
    end else begin
      WIN_READY <= (state_next == S_CONV);
      s1_valid  <= accept;
      if (frame_start)  cnt <= '0;
      else if (accept)  cnt <= cnt + 1'b1;
      if (accept) relu_q <= relu_c;
    end
  end

  // FC contribution of the registered window, using the ROM word that arrived this cycle.
  always_comb begin
    for (int q = 0; q < int'(N_CLASS); q++) begin
      fc_sum[q] = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        fc_sum[q] = fc_sum[q]
                  + ACC_W'($signed(relu_q[c*SUM_W +: SUM_W]))
                  * ACC_W'($signed(FC_RDATA[(N_CH*N_CLASS-1-(c*N_CLASS+q))*WT_W +: WT_W]));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || frame_start) begin
      for (int q = 0; q < int'(N_CLASS); q++) acc[q] <= '0;
    end else if (s1_valid) begin
      for (int q = 0; q < int'(N_CLASS); q++) acc[q] <= acc[q] + fc_sum[q];
    end
  end

  // Class 0 seeds the running best; later classes replace it only when strictly greater.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cls      <= '0;
      best     <= '0;
      best_idx <= '0;
      DONE     <= 1'b0;
      OUT      <= '0;
      SCORE    <= '0;
    end else begin
      if (arg_step) begin
        if (cls == '0 || acc[cls] > best) begin
          best     <= acc[cls];
          best_idx <= cls;
        end
        cls <= cls + 1'b1;
      end else begin
        cls <= '0;
      end
      DONE <= fin;
      if (fin) begin
        OUT   <= best_idx;
        SCORE <= best;
      end
    end
  end

endmodule

// File: tb/tb_param_cnn_core.sv
// Bench for param_cnn_core: table of frame stimuli plus abort/restart and START-hold sequences.
module tb_param_cnn_core;

  localparam int IMG_W   = 28;
  localparam int K       = 5;
  localparam int N_CH    = 2;
  localparam int N_CLASS = 10;
  localparam int PIX_W   = 8;
  localparam int WT_W    = 8;
  localparam int ACC_W   = 40;
  localparam int OUT_W   = IMG_W - K + 1;
  localparam int N_WIN   = OUT_W * OUT_W;
  localparam int KK      = K * K;
  localparam int IDX_W   = 10;
  localparam int CLS_W   = 4;
  localparam int BUDGET  = 4000;

  logic                         CLK;
  logic                         RST;
  logic                         START;
  logic                         WIN_VALID;
  logic                         WIN_READY;
  logic [KK*PIX_W-1:0]          WIN_DATA;
  logic [N_CH*KK*WT_W-1:0]      CONV_W;
  logic [IDX_W-1:0]             FC_ADDR;
  logic [N_CH*N_CLASS*WT_W-1:0] FC_RDATA;
  logic                         DONE;
  logic [CLS_W-1:0]             OUT;
  logic [ACC_W-1:0]             SCORE;

  param_cnn_core #(
    .IMG_W(IMG_W), .K(K), .N_CH(N_CH), .N_CLASS(N_CLASS),
    .PIX_W(PIX_W), .WT_W(WT_W), .ACC_W(ACC_W)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY),
    .WIN_DATA(WIN_DATA), .CONV_W(CONV_W), .FC_ADDR(FC_ADDR), .FC_RDATA(FC_RDATA),
    .DONE(DONE), .OUT(OUT), .SCORE(SCORE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stimulus in plain integer form, plus packed copies served to the DUT.
  int pix_a [N_WIN][KK];
  int kw    [N_CH][KK];
  int fw    [N_WIN][N_CH][N_CLASS];
  logic [KK*PIX_W-1:0]          win_mem [N_WIN];
  logic [N_CH*N_CLASS*WT_W-1:0] fc_mem  [N_WIN];

  // Synchronous FC weight ROM: data for the sampled address appears one cycle later.
  always @(posedge CLK) begin
    if (int'(FC_ADDR) < N_WIN) FC_RDATA <= fc_mem[FC_ADDR];
    else                       FC_RDATA <= '0;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setup(input int pm, input int km, input int fm);
    logic [KK*PIX_W-1:0]          w;
    logic [N_CH*KK*WT_W-1:0]      cw;
    logic [N_CH*N_CLASS*WT_W-1:0] f;
    cw = '0;
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < KK; i++) begin
        case (km)
          0:       kw[c][i] = (c == 0) ? 1 : 0;
          1:       kw[c][i] = -1;
          2:       kw[c][i] = (c == 1) ? 1 : 0;
          default: kw[c][i] = int'($urandom_range(255, 0)) - 128;
        endcase
        cw[(N_CH*KK-1-(c*KK+i))*WT_W +: WT_W] = WT_W'(kw[c][i]);
      end
    CONV_W = cw;
    for (int n = 0; n < N_WIN; n++) begin
      w = '0;
      f = '0;
      for (int i = 0; i < KK; i++) begin
        case (pm)
          0:       pix_a[n][i] = 1;
          1:       pix_a[n][i] = 2;
          default: pix_a[n][i] = int'($urandom_range(255, 0));
        endcase
        w[(KK-1-i)*PIX_W +: PIX_W] = PIX_W'(pix_a[n][i]);
      end
      for (int c = 0; c < N_CH; c++)
        for (int q = 0; q < N_CLASS; q++) begin
          case (fm)
            0:       fw[n][c][q] = (c == 0 && q == 3) ? 1 : 0;
            2:       fw[n][c][q] = (c == 1 && q == 7) ? 2 : 0;
            3:       fw[n][c][q] = int'($urandom_range(6, 0)) - 3;
            default: fw[n][c][q] = int'($urandom_range(255, 0)) - 128;
          endcase
          f[(N_CH*N_CLASS-1-(c*N_CLASS+q))*WT_W +: WT_W] = WT_W'(fw[n][c][q]);
        end
      win_mem[n] = w;
      fc_mem[n]  = f;
    end
  endtask

  // Reference: whole-frame scores from the integer arrays, wrapped to ACC_W bits, then argmax.
  task automatic model(output int eo, output longint es);
    longint sc [N_CLASS];
    longint conv;
    longint relu;
    for (int q = 0; q < N_CLASS; q++) sc[q] = 0;
    for (int n = 0; n < N_WIN; n++)
      for (int c = 0; c < N_CH; c++) begin
        conv = 0;
        for (int i = 0; i < KK; i++) conv += longint'(pix_a[n][i]) * longint'(kw[c][i]);
        relu = (conv > 0) ? conv : 0;
        for (int q = 0; q < N_CLASS; q++) sc[q] += relu * longint'(fw[n][c][q]);
      end
    for (int q = 0; q < N_CLASS; q++) sc[q] = (sc[q] <<< (64 - ACC_W)) >>> (64 - ACC_W);
    eo = 0;
    es = sc[0];
    for (int q = 1; q < N_CLASS; q++)
      if (sc[q] > es) begin
        es = sc[q];
        eo = q;
      end
  endtask

  int   done_cnt, done_cyc, last_cyc, acc_cnt, addr_err, ready_late;
  logic post_rst_done, post_rst_ready;
  logic [CLS_W-1:0] post_rst_out;
  logic [ACC_W-1:0] post_rst_score;

  // Drives one frame at the negedge; abort_at > 0 asserts RST once that many windows are in.
  task automatic run_frame(input int gap_pct, input bit hold_start, input int abort_at);
    bit aborted;
    done_cnt = 0; done_cyc = -1; last_cyc = -1; acc_cnt = 0;
    addr_err = 0; ready_late = 0; aborted = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge CLK);
      if (cyc == 1 && !hold_start) START = 1'b0;
      if (DONE) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        START = 1'b0;
      end
      if (last_cyc >= 0 && WIN_READY) ready_late++;
      if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
      if (abort_at > 0 && acc_cnt == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (acc_cnt < N_WIN) begin
        WIN_VALID = (int'($urandom_range(99, 0)) >= gap_pct);
        WIN_DATA  = win_mem[acc_cnt];
      end else begin
        WIN_VALID = 1'b1;
        WIN_DATA  = '1;
      end
      if (WIN_VALID && WIN_READY) begin
        if (int'(FC_ADDR) != acc_cnt) addr_err++;
        acc_cnt++;
        if (acc_cnt == N_WIN) last_cyc = cyc;
      end
    end
    WIN_VALID = 1'b0;
    START     = 1'b0;
    if (aborted) begin
      RST = 1'b1;
      @(negedge CLK);
      RST            = 1'b0;
      post_rst_done  = DONE;
      post_rst_ready = WIN_READY;
      post_rst_out   = OUT;
      post_rst_score = SCORE;
      for (int i = 0; i < 30; i++) begin
        @(negedge CLK);
        if (DONE) done_cnt++;
      end
    end
  endtask

  task automatic check_frame(input string name, input int exp_out, input longint exp_score);
    check({name, "_done_seen"}, longint'(done_cyc >= 0), 1);
    check({name, "_out"}, longint'(OUT), longint'(exp_out));
    check({name, "_score"}, longint'($signed(SCORE)), exp_score);
    check({name, "_done_pulses"}, done_cnt, 1);
    // DONE is first seen at the negedge following edge (last accept + N_CLASS + 2).
    check({name, "_latency"}, done_cyc - last_cyc, N_CLASS + 3);
    check({name, "_accepts"}, acc_cnt, N_WIN);
    check({name, "_addr_seq_errs"}, addr_err, 0);
    check({name, "_ready_after_last"}, ready_late, 0);
  endtask

  typedef struct {
    int     pm;
    int     km;
    int     fm;
    int     gap;
    bit     use_model;
    int     exp_out;
    longint exp_score;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1);
  end

  initial begin
    int     eo;
    longint es;
    int     idle_ready;

    vecs[0] = '{0, 0, 0, 0,  1'b0, 3, 64'd14400};
    vecs[1] = '{2, 1, 1, 0,  1'b0, 0, 64'd0};
    vecs[2] = '{1, 2, 2, 0,  1'b0, 7, 64'd57600};
    vecs[3] = '{0, 0, 0, 50, 1'b0, 3, 64'd14400};
    vecs[4] = '{2, 3, 1, 25, 1'b1, 0, 64'd0};
    vecs[5] = '{2, 3, 3, 0,  1'b1, 0, 64'd0};
    vecs[6] = '{2, 3, 1, 50, 1'b1, 0, 64'd0};

    RST = 1'b1; START = 1'b0; WIN_VALID = 1'b0; WIN_DATA = '0; CONV_W = '0;
    repeat (3) @(negedge CLK);
    check("rst_done", longint'(DONE), 0);
    check("rst_out", longint'(OUT), 0);
    check("rst_score", longint'(SCORE), 0);
    check("rst_ready", longint'(WIN_READY), 0);
    RST = 1'b0;

    // WIN_VALID while idle must never see ready.
    idle_ready = 0;
    WIN_VALID  = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (WIN_READY) idle_ready++;
    end
    WIN_VALID = 1'b0;
    check("idle_valid_ready", idle_ready, 0);

    // RST and START together: reset wins, no frame starts.
    START = 1'b1;
    RST   = 1'b1;
    @(negedge CLK);
    check("rst_start_ready0", longint'(WIN_READY), 0);
    START = 1'b0;
    RST   = 1'b0;
    @(negedge CLK);
    check("rst_start_ready1", longint'(WIN_READY), 0);

    for (int v = 0; v < 7; v++) begin
      setup(vecs[v].pm, vecs[v].km, vecs[v].fm);
      if (vecs[v].use_model) begin
        model(eo, es);
        vecs[v].exp_out   = eo;
        vecs[v].exp_score = es;
      end
      run_frame(vecs[v].gap, 1'b0, 0);
      check_frame($sformatf("v%0d", v), vecs[v].exp_out, vecs[v].exp_score);
    end

    // START held high through CONV and FIN must not restart the frame.
    setup(1, 2, 2);
    run_frame(0, 1'b1, 0);
    check_frame("hold_start", 7, 64'd57600);

    // Abort after 300 windows: outputs return to reset values and DONE never fires.
    setup(0, 0, 0);
    run_frame(0, 1'b0, 300);
    check("abort_accepts", acc_cnt, 300);
    check("abort_done_pulses", done_cnt, 0);
    check("abort_done", longint'(post_rst_done), 0);
    check("abort_ready", longint'(post_rst_ready), 0);
    check("abort_out", longint'(post_rst_out), 0);
    check("abort_score", longint'(post_rst_score), 0);

    setup(2, 1, 1);
    run_frame(25, 1'b0, 0);
    check_frame("restart", 0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
